spectrum_upload_framer: RTL

- Reader/transmitter side of the accumulated power-spectrum buffer.
- On an upload trigger it drains exactly n_bins*n_points 64-bit words from the accumulation FIFO and wraps them in a frame: two header words, then the payload, then an XOR checksum tail.
- The frame is streamed onto the 64-bit host output (y0/y0z/y1/y1z lanes) with a valid strobe.
- It sits between the accumulation buffer and the top-level output registers.

---
 rtl/spectrum_upload_framer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/spectrum_upload_framer.sv
// Upload framer for the accumulated power spectrum: drains n_bins*n_points FIFO words
// and streams them as header, payload and XOR checksum words on the 64-bit host port.
module spectrum_upload_framer #(
    parameter int          DATA_W    = 64,
    parameter logic [15:0] HDR_MAGIC = 16'hA55A,
    parameter int          TIMEOUT   = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [15:0]       n_bins_i,
    input  logic [15:0]       n_points_i,
    input  logic [15:0]       group_id_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_dout_i,
    input  logic              fifo_empty_i,
    output logic [DATA_W-1:0] y_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_TAIL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_bins_q, n_bins_d;
    logic [15:0]       n_points_q, n_points_d;
    logic [15:0]       group_q, group_d;
    logic [31:0]       total_q, total_d;
    logic [31:0]       reads_q, reads_d;
    logic [31:0]       words_q, words_d;
    logic [CNT_W-1:0]  empty_q, empty_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              sel_fifo_q, sel_fifo_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              need_read;
    logic              rd_en;
    logic [31:0]       words_nx;
    logic [DATA_W-1:0] csum_nx;
    logic [DATA_W-1:0] hdr0_word;

    assign hdr0_word = DATA_W'({HDR_MAGIC, group_q, n_bins_q, n_points_q});

    // The first read goes out during HDR1 so the payload follows the header without a bubble.
    assign need_read = (reads_q < total_q) && !err_q;
    assign rd_en     = ((state_q == S_HDR1) || (state_q == S_PAYLOAD)) && need_read && !fifo_empty_i;
    assign words_nx  = words_q + {31'b0, sel_fifo_q};
    assign csum_nx   = sel_fifo_q ? (csum_q ^ fifo_dout_i) : csum_q;

    // Payload words are passed straight from the FIFO read port for single-cycle latency.
    assign y_o          = sel_fifo_q ? fifo_dout_i : ((state_q == S_HDR0) ? hdr0_word : y_q);
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign fifo_rd_en_o = rd_en;

    always_comb begin
        state_d    = state_q;
        n_bins_d   = n_bins_q;
        n_points_d = n_points_q;
        group_d    = group_q;
        total_d    = total_q;
        reads_d    = reads_q;
        words_d    = words_q;
        empty_d    = empty_q;
        csum_d     = csum_q;
        y_d        = y_o;
        sel_fifo_d = 1'b0;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_bins_d   = n_bins_i;
                    n_points_d = n_points_i;
                    group_d    = group_id_i;
                    total_d    = 32'(n_bins_i) * 32'(n_points_i);
                    reads_d    = 32'd0;
                    words_d    = 32'd0;
                    empty_d    = '0;
                    csum_d     = '0;
                    err_d      = 1'b0;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_HDR0;
                end
            end
            S_HDR0: begin
                y_d     = DATA_W'({total_q, 32'h0});
                valid_d = 1'b1;
                state_d = S_HDR1;
            end
            S_HDR1: begin
                if (total_q == 32'd0) begin
                    y_d     = csum_q;
                    valid_d = 1'b1;
                    state_d = S_TAIL;
                end else begin
                    reads_d    = reads_q + {31'b0, rd_en};
                    sel_fifo_d = rd_en;
                    valid_d    = rd_en;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                reads_d    = reads_q + {31'b0, rd_en};
                sel_fifo_d = rd_en;
                valid_d    = rd_en;
                words_d    = words_nx;
                csum_d     = csum_nx;
                if (rd_en) begin
                    empty_d = '0;
                end else if (need_read && fifo_empty_i && (empty_q != CNT_W'(TIMEOUT))) begin
                    empty_d = empty_q + CNT_W'(1);
                end
                if (empty_d == CNT_W'(TIMEOUT)) begin
                    err_d = 1'b1;
                end
                // A timeout only fires on a cycle with no read issued, so nothing is left in flight.
                if ((words_nx == total_q) || err_d) begin
                    y_d        = csum_nx;
                    valid_d    = 1'b1;
                    sel_fifo_d = 1'b0;
                    state_d    = S_TAIL;
                end
            end
            S_TAIL: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            n_bins_q   <= '0;
            n_points_q <= '0;
            group_q    <= '0;
            total_q    <= '0;
            reads_q    <= '0;
            words_q    <= '0;
            empty_q    <= '0;
            csum_q     <= '0;
            y_q        <= '0;
            sel_fifo_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_bins_q   <= n_bins_d;
            n_points_q <= n_points_d;
            group_q    <= group_d;
            total_q    <= total_d;
            reads_q    <= reads_d;
            words_q    <= words_d;
            empty_q    <= empty_d;
            csum_q     <= csum_d;
            y_q        <= y_d;
            sel_fifo_q <= sel_fifo_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule
